// File: rtl/ofifo_pkg.sv
// Shared defaults and helpers for the skewed output FIFO (ofifo_skew).
package ofifo_pkg;

  localparam int COL_DEF   = 8;
  localparam int BW_DEF    = 16;
  localparam int DEPTH_DEF = 64;

  // Occupancy counters need one extra bit so that DEPTH itself is representable.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ofifo_col_buf.sv
// One column of the skewed output FIFO: single-clock BW x DEPTH FIFO with
// first-word-fall-through head and occupancy count. Caller guards wr/rd.
module ofifo_col_buf
  import ofifo_pkg::*;
#(
  parameter int BW    = BW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr,
  input  logic [BW-1:0]                 wdata,
  input  logic                          rd,
  output logic [BW-1:0]                 head,
  output logic [cnt_width(DEPTH)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [BW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;

  // Storage sits in the reset block so that no write can land while reset is low;
  // the array itself is not cleared, pointers and count make it invisible.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + 1'b1;
      end
      if (rd) begin
        rptr <= rptr + 1'b1;
      end
      case ({wr, rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rptr];

endmodule

// File: rtl/ofifo_skew.sv
// Skewed output FIFO: COL row-aligned column FIFOs, column i written i cycles
// after column 0. Optional sticky error flags under OFIFO_ERR_FLAG_EN.
module ofifo_skew
  import ofifo_pkg::*;
#(
  parameter int COL   = 8,
  parameter int BW    = 16,
  parameter int DEPTH = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr,
  input  logic [COL*BW-1:0]             in,
  input  logic                          rd,
  output logic [COL*BW-1:0]             out,
  output logic                          o_valid,
  output logic                          o_full,
  output logic                          o_ready,
  output logic [cnt_width(DEPTH)-1:0]   o_count
`ifdef OFIFO_ERR_FLAG_EN
  ,
  output logic [1:0]                    o_err
`endif
);

  localparam int CW = cnt_width(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Handshake: a row write is taken when wr && o_ready in the same cycle; a pop
  // happens when rd && o_valid. Both are judged on pre-edge state, so a full
  // FIFO that is popped still refuses the write offered in that cycle.
  logic wr_acc;
  logic rd_ok;

  assign o_ready = !o_full;
  assign wr_acc  = wr && o_ready;
  assign rd_ok   = rd && o_valid;

  // Write-request skew chain: bit k is the accepted wr delayed by k+1 cycles.
  logic [COL-2:0] skew_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      skew_q <= '0;
    end else begin
      skew_q[0] <= wr_acc;
      for (int k = 1; k < COL - 1; k++) begin
        skew_q[k] <= skew_q[k-1];
      end
    end
  end

  logic [COL-1:0] col_wr;
  logic [COL-1:0] col_we;
  logic [COL-1:0] col_re;
  logic [BW-1:0]  col_head [COL];
  logic [CW-1:0]  col_cnt  [COL];

  assign col_wr = {skew_q, wr_acc};

  for (genvar i = 0; i < COL; i++) begin : g_col
    // Per-column guards keep every counter within 0..DEPTH even if rows ever lost alignment.
    assign col_we[i] = col_wr[i] && (col_cnt[i] != FULL_CNT);
    assign col_re[i] = rd_ok && (col_cnt[i] != '0);

    ofifo_col_buf #(
      .BW    (BW),
      .DEPTH (DEPTH)
    ) u_col (
      .clk   (clk),
      .reset (reset),
      .wr    (col_we[i]),
      .wdata (in[i*BW +: BW]),
      .rd    (col_re[i]),
      .head  (col_head[i]),
      .count (col_cnt[i])
    );

    assign out[i*BW +: BW] = o_valid ? col_head[i] : '0;
  end

  // Column 0 sees every accepted row first, the last column holds complete rows.
  assign o_full  = (col_cnt[0] == FULL_CNT);
  assign o_count = col_cnt[COL-1];
  assign o_valid = (col_cnt[COL-1] != '0);

`ifdef OFIFO_ERR_FLAG_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_err <= 2'b00;
    end else begin
      if (wr && o_full)   o_err[0] <= 1'b1;
      if (rd && !o_valid) o_err[1] <= 1'b1;
    end
  end
`endif

endmodule

// File: doc/ofifo_skew.md
OFIFO_SKEW -- requirements
Module: ofifo_skew

Interface
REQ-001 Parameter COL, default 8, number of output columns (channels), SHALL be at least 2.
REQ-002 Parameter BW, default 16, data bits per column.
REQ-003 Parameter DEPTH, default 64, rows per column, SHALL be a power of 2 and at least 4.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 wr  input  1  row-write request for column 0; the same request reaches column i i cycles later.
REQ-007 in  input  COL*BW  column i data at bits [(i+1)*BW-1:i*BW].
REQ-008 rd  input  1  pop one aligned row from all columns.
REQ-009 out  output  COL*BW  head row, column-sliced like in.
REQ-010 o_valid  output  1  at least one complete row is stored.
REQ-011 o_full  output  1  column 0 holds DEPTH rows.
REQ-012 o_ready  output  1  equals !o_full.
REQ-013 o_count  output  $clog2(DEPTH)+1  number of complete rows (column COL-1 occupancy).
REQ-014 o_err  output  2  sticky flags: {underflow, overflow}; present only under OFIFO_ERR_FLAG_EN.

Function
REQ-015 A wr accepted in cycle t SHALL write in[column i] into column i at the clock edge ending cycle t+i (skew chain, COL-1 delay stages).
REQ-016 wr SHALL be accepted only when o_full=0 in that cycle; a rejected wr SHALL NOT enter the skew chain, so columns stay row-aligned.
REQ-017 rd SHALL be honoured only when o_valid=1; an honoured rd pops the head of every column at that edge.
REQ-018 o_valid SHALL be 1 iff column COL-1 is non-empty; after one accepted wr into an empty FIFO, it rises in cycle t+COL.
REQ-019 out SHALL be the combinational head of each column (first-word fall-through) when o_valid=1, and all zeros when o_valid=0.
REQ-020 o_full SHALL be 1 iff column 0 occupancy equals DEPTH; column i occupancy is never greater than column 0 occupancy.
REQ-021 Simultaneous honoured rd and accepted wr SHALL leave column 0 occupancy unchanged.
REQ-022 When o_full=1 and rd=1 in the same cycle, the rd SHALL be honoured and the wr SHALL still be rejected (o_full is evaluated before the pop).
REQ-023 Read and write pointers SHALL wrap modulo DEPTH without loss or reordering.
REQ-024 Each column occupancy counter SHALL be $clog2(DEPTH)+1 bits wide and SHALL never exceed DEPTH or go below 0.

Reset
REQ-025 reset=0 SHALL asynchronously clear the skew chain, all pointers, all counters and both o_err bits, giving o_valid=0, o_full=0, o_ready=1, o_count=0, out=0.
REQ-026 Asserting reset mid-burst SHALL discard all stored and in-flight rows; no column write may occur while reset=0.

Configuration
REQ-027 With OFIFO_ERR_FLAG_EN defined:
- o_err[0] SHALL set on a rejected wr.
- o_err[1] SHALL set on rd while o_valid=0.
- Both bits SHALL stay set until reset.
REQ-028 Without OFIFO_ERR_FLAG_EN, the o_err port and its logic SHALL be absent; rejected wr and rd SHALL still be silently ignored.

Structure
REQ-029 Package ofifo_pkg SHALL hold the default COL/BW/DEPTH constants and the count-width function.
REQ-030 Per-column storage SHALL be sub-module ofifo_col_buf: single-clock FIFO, BW x DEPTH, with FWFT head output and an occupancy count.

Verification (COL=4, BW=4, DEPTH=8)
REQ-031 Apply reset=0 -> o_valid=0, o_full=0, o_ready=1, o_count=0, out=16'h0000, o_err=2'b00.
REQ-032 One wr in cycle 0 with in=16'h4321 held for cycles 0-3 -> o_valid=1 first in cycle 4, out=16'h4321, o_count=1.
REQ-033 8 consecutive wr -> o_full=1 in cycle 8; a 9th wr is rejected, o_count settles at 8, o_err[0]=1.
REQ-034 rd with the FIFO empty -> ignored, out=0, o_count=0, o_err[1]=1.
REQ-035 Stream 20 rows (values 0-19 per column) with rd whenever o_valid=1 -> pointers wrap and rows are read back in order 0-19 with no loss.
REQ-036 Drive reset=0 mid-stream at o_count=5 -> all outputs return immediately to their reset values; no write lands during reset.
